// File: rtl/anti_theft_fsm.sv
// anti_theft_fsm
//   Car-alarm controller. It watches the ignition and door inputs and the
//   timer's expired pulse. It drives start_timer/timer_value/interval for the
//   downstream timer from a reprogrammable 4-entry delay table. It produces
//   the siren, status_led and EA_DISPLAY outputs.
//
//   clock          in   system clock
//   reset          in   synchronous, active-high reset
//   ignition       in   ignition switch level
//   door_driver    in   1 = driver door open
//   door_pass      in   1 = passenger door open
//   reprogram      in   1-cycle write strobe for the delay table
//   time_param_sel in   table index written on reprogram
//   time_value     in   value written on reprogram
//   expired        in   timer run finished (1-cycle pulse)
//   one_hz_enable  in   timer blink square wave
//   start_timer    out  1-cycle start pulse to the timer
//   timer_value    out  delay in seconds, held between starts
//   interval       out  table index of the current/last countdown
//   siren          out  siren enable
//   status_led     out  status indicator
//   EA_DISPLAY     out  current state code
module anti_theft_fsm #(
  parameter logic [3:0] T_ARM_DELAY       = 4'd6,
  parameter logic [3:0] T_DRIVER_DELAY    = 4'd8,
  parameter logic [3:0] T_PASSENGER_DELAY = 4'd15,
  parameter logic [3:0] T_ALARM_ON        = 4'd10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ignition,
  input  logic       door_driver,
  input  logic       door_pass,
  input  logic       reprogram,
  input  logic [1:0] time_param_sel,
  input  logic [3:0] time_value,
  input  logic       expired,
  input  logic       one_hz_enable,
  output logic       start_timer,
  output logic [3:0] timer_value,
  output logic [1:0] interval,
  output logic       siren,
  output logic       status_led,
  output logic [2:0] EA_DISPLAY
);

  typedef enum logic [2:0] {
    ARMED          = 3'd0,
    TRIGGERED      = 3'd1,
    ALARM          = 3'd2,
    DIS_IGN_ON     = 3'd3,
    DIS_WAIT_OPEN  = 3'd4,
    DIS_WAIT_CLOSE = 3'd5,
    ARM_DELAY      = 3'd6
  } state_t;

  state_t     state, state_next;
  logic [3:0] delay_table [4];

  logic       owned, owned_next, owned_keep;
  logic       pending, pending_next;
  logic [1:0] pend_sel, pend_sel_next;
  logic       req;
  logic [1:0] req_sel, issue_sel;
  logic       doors_closed, valid_exp, counting;
  logic       start_next;
  logic [3:0] value_next;
  logic [1:0] interval_next;

  // Next-state and start-request decode
  always_comb begin
    state_next   = state;
    owned_keep   = 1'b1;
    req          = 1'b0;
    req_sel      = '0;
    doors_closed = !door_driver && !door_pass;
    // an expiry in the cycle a start goes out belongs to the previous run
    valid_exp    = expired && owned && !start_timer;

    case (state)
      ARMED: begin
        if (ignition) state_next = DIS_IGN_ON;
        else if (door_driver) begin
          state_next = TRIGGERED;
          req        = 1'b1;
          req_sel    = 2'd1;
        end else if (door_pass) begin
          state_next = TRIGGERED;
          req        = 1'b1;
          req_sel    = 2'd2;
        end
      end
      TRIGGERED: begin
        if (ignition) state_next = DIS_IGN_ON;
        else if (valid_exp) begin
          state_next = ALARM;
          if (doors_closed) begin
            req     = 1'b1;
            req_sel = 2'd3;
          end else begin
            // no run in flight: ALARM restarts it once the doors close
            owned_keep = 1'b0;
          end
        end
      end
      ALARM: begin
        if (ignition) state_next = DIS_IGN_ON;
        else if (!doors_closed) owned_keep = 1'b0;
        else if (!owned) begin
          req     = 1'b1;
          req_sel = 2'd3;
        end else if (valid_exp) state_next = ARMED;
      end
      DIS_IGN_ON: begin
        if (!ignition) state_next = DIS_WAIT_OPEN;
      end
      DIS_WAIT_OPEN: begin
        if (ignition) state_next = DIS_IGN_ON;
        else if (door_driver) state_next = DIS_WAIT_CLOSE;
      end
      DIS_WAIT_CLOSE: begin
        if (ignition) state_next = DIS_IGN_ON;
        else if (doors_closed) begin
          state_next = ARM_DELAY;
          req        = 1'b1;
          req_sel    = 2'd0;
        end
      end
      ARM_DELAY: begin
        if (ignition) state_next = DIS_IGN_ON;
        else if (!doors_closed) state_next = DIS_WAIT_CLOSE;
        else if (valid_exp) state_next = ARMED;
      end
      default: state_next = ARMED;
    endcase

    if (reprogram) begin
      state_next = ARMED;
      req        = 1'b0;
      owned_keep = 1'b0;
    end

    counting   = (state_next == TRIGGERED) || (state_next == ALARM) ||
                 (state_next == ARM_DELAY);
    owned_next = counting && (req || (owned && owned_keep));
  end

  // Start issue: a start colliding with expired is re-sent next cycle (the
  // timer drops it in DONE); otherwise starts never go out back to back, so a
  // request arriving while a start is on the wire waits one cycle.
  always_comb begin
    start_next    = 1'b0;
    value_next    = timer_value;
    interval_next = interval;
    pending_next  = 1'b0;
    pend_sel_next = pend_sel;
    issue_sel     = req ? req_sel : pend_sel;
    if (owned_next) begin
      if (start_timer) begin
        start_next   = expired;
        pending_next = req || pending;
        if (req) pend_sel_next = req_sel;
      end else if (req || pending) begin
        start_next    = 1'b1;
        value_next    = delay_table[issue_sel];
        interval_next = issue_sel;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= ARMED;
      delay_table[0] <= T_ARM_DELAY;
      delay_table[1] <= T_DRIVER_DELAY;
      delay_table[2] <= T_PASSENGER_DELAY;
      delay_table[3] <= T_ALARM_ON;
      owned          <= 1'b0;
      pending        <= 1'b0;
      pend_sel       <= '0;
      start_timer    <= 1'b0;
      timer_value    <= '0;
      interval       <= '0;
    end else begin
      if (reprogram) delay_table[time_param_sel] <= time_value;
      state       <= state_next;
      owned       <= owned_next;
      pending     <= pending_next;
      pend_sel    <= pend_sel_next;
      start_timer <= start_next;
      timer_value <= value_next;
      interval    <= interval_next;
    end
  end

  always_comb begin
    siren      = (state == ALARM);
    EA_DISPLAY = state;
    case (state)
      ARMED:            status_led = one_hz_enable;
      TRIGGERED, ALARM: status_led = 1'b1;
      default:          status_led = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_anti_theft_fsm.sv
// tb_anti_theft_fsm
//   Bench for anti_theft_fsm: drives expired directly in place of a timer.
module tb_anti_theft_fsm;

  logic       clock = 1'b0;
  logic       reset, ignition, door_driver, door_pass, reprogram;
  logic [1:0] time_param_sel;
  logic [3:0] time_value;
  logic       expired, one_hz_enable;
  logic       start_timer;
  logic [3:0] timer_value;
  logic [1:0] interval;
  logic       siren, status_led;
  logic [2:0] EA_DISPLAY;

  always #5 clock = ~clock;

  anti_theft_fsm #(
    .T_ARM_DELAY      (4'd6),
    .T_DRIVER_DELAY   (4'd8),
    .T_PASSENGER_DELAY(4'd15),
    .T_ALARM_ON       (4'd10)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .ignition      (ignition),
    .door_driver   (door_driver),
    .door_pass     (door_pass),
    .reprogram     (reprogram),
    .time_param_sel(time_param_sel),
    .time_value    (time_value),
    .expired       (expired),
    .one_hz_enable (one_hz_enable),
    .start_timer   (start_timer),
    .timer_value   (timer_value),
    .interval      (interval),
    .siren         (siren),
    .status_led    (status_led),
    .EA_DISPLAY    (EA_DISPLAY)
  );

  typedef struct {
    logic       rst, ign, dd, dp, rp;
    logic [1:0] sel;
    logic [3:0] val;
    logic       exp, hz;
    logic [2:0] st;
    logic       stt;
    logic [3:0] tv;
    logic [1:0] iv;
    logic       sir, led;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(int rst, int ign, int dd, int dp, int rp, int sel,
                              int val, int exp, int hz, int st, int stt, int tv,
                              int iv, int sir, int led);
    vec_t r;
    r.rst = rst[0]; r.ign = ign[0]; r.dd = dd[0]; r.dp = dp[0]; r.rp = rp[0];
    r.sel = sel[1:0]; r.val = val[3:0]; r.exp = exp[0]; r.hz = hz[0];
    r.st = st[2:0]; r.stt = stt[0]; r.tv = tv[3:0]; r.iv = iv[1:0];
    r.sir = sir[0]; r.led = led[0];
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic drive(input vec_t v);
    reset = v.rst; ignition = v.ign; door_driver = v.dd; door_pass = v.dp;
    reprogram = v.rp; time_param_sel = v.sel; time_value = v.val;
    expired = v.exp; one_hz_enable = v.hz;
  endtask

  task automatic idle_inputs();
    reset = 1'b0; ignition = 1'b0; door_driver = 1'b0; door_pass = 1'b0;
    reprogram = 1'b0; time_param_sel = '0; time_value = '0; expired = 1'b0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t e;
    bit   found;
    //              rst ign dd dp rp sel val exp hz | st stt tv iv sir led
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 1)); // reset
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 1,   1, 1, 8, 1, 0, 1)); // driver door
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1,   1, 0, 8, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1,   2, 1,10, 3, 1, 1)); // -> ALARM
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1,   2, 1,10, 3, 1, 1)); // collision re-start
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1,   2, 0,10, 3, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0,   0, 0,10, 3, 0, 0)); // -> ARMED
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1,   0, 0,10, 3, 0, 1));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 1,   1, 1,15, 2, 0, 1)); // passenger door
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 1,   3, 0,15, 2, 0, 0)); // ignition disarm
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 1,   3, 0,15, 2, 0, 0)); // expired ignored
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1,   4, 0,15, 2, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 1,   5, 0,15, 2, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1,   6, 1, 6, 0, 0, 0)); // arm delay
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 1,   5, 0, 6, 0, 0, 0)); // reopen
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1,   6, 1, 6, 0, 0, 0)); // fresh start
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1,   6, 0, 6, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1,   0, 0, 6, 0, 0, 1)); // armed again
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 1,   1, 1, 8, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1,   1, 0, 8, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1,   2, 1,10, 3, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1,   2, 0,10, 3, 1, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 1,   2, 0,10, 3, 1, 1)); // door + expired
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1,   2, 1,10, 3, 1, 1)); // restart(10)
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1,   2, 0,10, 3, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1,   0, 0,10, 3, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 1,   3, 0,10, 3, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 2, 3, 0, 1,   0, 0,10, 3, 0, 1)); // reprogram t[2]=3
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 1,   1, 1, 3, 2, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1,   1, 0, 3, 2, 0, 1));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1, 1,   2, 0, 3, 2, 1, 1)); // alarm, door open
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1,   2, 1,10, 3, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1,   2, 0,10, 3, 1, 1));
    vecs.push_back(mk(0, 0, 1, 0, 1, 3, 0, 0, 1,   0, 0,10, 3, 0, 1)); // reprogram t[3]=0
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 1,   1, 1, 8, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1,   1, 0, 8, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1,   2, 1, 0, 3, 1, 1)); // zero delay
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1,   2, 0, 0, 3, 1, 1));
    vecs.push_back(mk(1, 0, 0, 0, 1, 2, 7, 0, 1,   0, 0, 0, 0, 0, 1)); // reset beats reprogram
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 1,   1, 1,15, 2, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 1,   3, 0,15, 2, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1,   4, 0,15, 2, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 1,   3, 0,15, 2, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1,   4, 0,15, 2, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 1,   5, 0,15, 2, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 1,   3, 0,15, 2, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1,   4, 0,15, 2, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      sb.push_back(vecs[i]);
      step();
      e = sb.pop_front();
      check($sformatf("v%0d.state", i),  32'(EA_DISPLAY),  32'(e.st));
      check($sformatf("v%0d.start", i),  32'(start_timer), 32'(e.stt));
      check($sformatf("v%0d.value", i),  32'(timer_value), 32'(e.tv));
      check($sformatf("v%0d.interval", i), 32'(interval),  32'(e.iv));
      check($sformatf("v%0d.siren", i),  32'(siren),       32'(e.sir));
      check($sformatf("v%0d.led", i),    32'(status_led),  32'(e.led));
    end

    // Disarmed walk-away: one start pulse, then the arm delay expires.
    idle_inputs();
    door_driver = 1'b1;
    step();
    check("seq1.wait_close", 32'(EA_DISPLAY), 32'd5);
    door_driver = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (start_timer) begin
        found = 1'b1;
        break;
      end
    end
    check("seq1.start_seen", 32'(found), 32'd1);
    check("seq1.arm_delay", 32'(EA_DISPLAY), 32'd6);
    check("seq1.value", 32'(timer_value), 32'd6);
    step();
    check("seq1.single_pulse", 32'(start_timer), 32'd0);
    repeat (3) step();
    check("seq1.still_waiting", 32'(EA_DISPLAY), 32'd6);
    expired = 1'b1;
    step();
    expired = 1'b0;
    check("seq1.armed", 32'(EA_DISPLAY), 32'd0);

    // Armed LED follows the blink input combinationally.
    for (int k = 0; k < 4; k++) begin
      one_hz_enable = (k % 2 == 1);
      #2;
      check($sformatf("seq2.led%0d", k), 32'(status_led), 32'(one_hz_enable));
      check($sformatf("seq2.siren%0d", k), 32'(siren), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
